store_merge_unit: RTL and testbench

Parametrised read-modify-write engine for sub-word stores (SB/SH/SW/SD) between the datapath's store stage and data memory. It accepts one store request at a time and splices the store bytes into the addressed memory word at the correct byte lane. Partial stores fetch the current word, merge, and write it back. Full-word stores bypass the read, and misaligned requests are rejected without touching memory.

---
 rtl/store_merge_if.sv | 36 +++
 rtl/store_merge_unit.sv | 88 ++++++++
 tb/tb_store_merge_unit.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_merge_if.sv
// Store merge port bundle: store-stage request channel plus level-handshake memory port.
// Carries no logic; slave is the merge engine, master is whatever drives it.
interface store_merge_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_ack;
    logic              done;
    logic              misaligned;
    logic              busy;

    modport slave (
        input  req_valid, req_addr, req_size, req_data,
        input  mem_rd_valid, mem_rd_data, mem_wr_ack,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output done, misaligned, busy
    );

    modport master (
        output req_valid, req_addr, req_size, req_data,
        output mem_rd_valid, mem_rd_data, mem_wr_ack,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  done, misaligned, busy
    );
endinterface

// File: rtl/store_merge_unit.sv
// Sub-word store read-modify-write engine: splices store bytes into the addressed memory word.
// Latency: partial store R+W+2 cycles, full-word store W+1, rejected request 1 cycle.
// Backpressure: one request in flight; req_ready only in IDLE, memory side waits on rd_valid/wr_ack.
module store_merge_unit #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input logic          clk,
    input logic          rst_n,
    store_merge_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic [OFF_W-1:0]  off_in, off_q;
    logic [3:0]        n_in, n_q;
    logic [DATA_W-1:0] data_q, rd_q, wr_q, merged, data_sh;
    logic [ADDR_W-1:0] addr_q;
    logic [BYTES-1:0]  be;
    logic              accept, reject, full;

    assign off_in = bus.req_addr[OFF_W-1:0];
    assign n_in   = 4'd1 << bus.req_size;
    assign accept = bus.req_valid && (state == IDLE);
    // n is a power of two, so the alignment test is a mask rather than a modulo
    assign reject = ((int'(off_in) & (int'(n_in) - 1)) != 0) || (int'(n_in) > BYTES);
    assign full   = (int'(n_in) == BYTES);

    assign data_sh = data_q << {off_q, 3'b000};

    always_comb begin
        be     = '0;
        merged = '0;
        for (int i = 0; i < BYTES; i++) begin
            be[i] = (i >= int'(off_q)) && (i < int'(off_q) + int'(n_q));
            merged[8*i +: 8] = be[i] ? data_sh[8*i +: 8] : rd_q[8*i +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = reject ? ERR : (full ? WRITE : READ);
            READ:     if (bus.mem_rd_valid) state_nxt = MERGE;
            MERGE:    state_nxt = WRITE;
            WRITE:    if (bus.mem_wr_ack) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            ERR:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            off_q  <= '0;
            n_q    <= '0;
            data_q <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                off_q  <= off_in;
                n_q    <= n_in;
                data_q <= bus.req_data;
                addr_q <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                // full-word stores skip READ/MERGE, so the write word is the request itself
                if (full && !reject) wr_q <= bus.req_data;
            end
            if (state == READ && bus.mem_rd_valid) rd_q <= bus.mem_rd_data;
            if (state == MERGE) wr_q <= merged;
        end
    end

    assign bus.req_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.mem_rd_en   = (state == READ);
    assign bus.mem_wr_en   = (state == WRITE);
    assign bus.done        = (state == DONE);
    assign bus.misaligned  = (state == ERR);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: 64-bit and 32-bit instances behind one selectable driver,
// randomized stores checked against a byte-array merge model and the documented cycle timing.
module tb_store_merge_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel32;
    logic        req_valid, rd_valid, wr_ack;
    logic [63:0] req_addr, req_data, rd_data;
    logic [1:0]  req_size;

    store_merge_if #(64, 64) b64();
    store_merge_if #(32, 64) b32();

    store_merge_unit #(.DATA_W(64), .ADDR_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    store_merge_unit #(.DATA_W(32), .ADDR_W(64)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));

    assign b64.req_valid    = req_valid & ~sel32;
    assign b64.req_addr     = req_addr;
    assign b64.req_size     = req_size;
    assign b64.req_data     = req_data;
    assign b64.mem_rd_valid = rd_valid & ~sel32;
    assign b64.mem_rd_data  = rd_data;
    assign b64.mem_wr_ack   = wr_ack & ~sel32;
    assign b32.req_valid    = req_valid & sel32;
    assign b32.req_addr     = req_addr;
    assign b32.req_size     = req_size;
    assign b32.req_data     = req_data[31:0];
    assign b32.mem_rd_valid = rd_valid & sel32;
    assign b32.mem_rd_data  = rd_data[31:0];
    assign b32.mem_wr_ack   = wr_ack & sel32;

    logic        o_ready, o_busy, o_rd_en, o_wr_en, o_done, o_mis;
    logic [63:0] o_addr, o_wdata;
    assign o_ready = sel32 ? b32.req_ready  : b64.req_ready;
    assign o_busy  = sel32 ? b32.busy       : b64.busy;
    assign o_rd_en = sel32 ? b32.mem_rd_en  : b64.mem_rd_en;
    assign o_wr_en = sel32 ? b32.mem_wr_en  : b64.mem_wr_en;
    assign o_done  = sel32 ? b32.done       : b64.done;
    assign o_mis   = sel32 ? b32.misaligned : b64.misaligned;
    assign o_addr  = sel32 ? b32.mem_addr   : b64.mem_addr;
    assign o_wdata = sel32 ? {32'h0, b32.mem_wr_data} : b64.mem_wr_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          done_cyc;
        int          mis_cyc;
        int          rd_cyc;
        int          wr_cyc;
        int          done_cnt;
        logic [63:0] wdata;
        bit          stable;
        bit          addr_ok;
        logic        ready0;
    } res_t;

    function automatic int nbytes();
        return sel32 ? 4 : 8;
    endfunction

    function automatic bit model_reject(input logic [63:0] a, input logic [1:0] sz);
        int bytes = nbytes();
        int off   = int'(a[2:0]) % bytes;
        int n     = 1 << sz;
        return ((off % n) != 0) || (n > bytes);
    endfunction

    function automatic logic [63:0] model_merge(input logic [63:0] mem, input logic [63:0] a,
                                                input logic [63:0] d, input logic [1:0] sz);
        logic [7:0]  w [8];
        logic [63:0] res = '0;
        int bytes = nbytes();
        int off   = int'(a[2:0]) % bytes;
        int n     = 1 << sz;
        for (int i = 0; i < 8; i++) w[i] = mem[8*i +: 8];
        for (int k = 0; k < n; k++) w[off + k] = d[8*k +: 8];
        for (int i = 0; i < bytes; i++) res[8*i +: 8] = w[i];
        return res;
    endfunction

    // Drives one request and plays the memory with read latency R and write latency W.
    task automatic run_store(input logic [63:0] a, input logic [63:0] d, input logic [63:0] mem,
                             input logic [1:0] sz, input int rl, input int wl, output res_t r);
        logic [63:0] exp_addr = a & ~(64'(nbytes()) - 64'd1);
        r = '{done_cyc: -1, mis_cyc: -1, rd_cyc: 0, wr_cyc: 0, done_cnt: 0,
              wdata: '0, stable: 1'b1, addr_ok: 1'b1, ready0: 1'b0};
        @(negedge clk);
        r.ready0  = o_ready;
        req_valid = 1'b1; req_addr = a; req_size = sz; req_data = d;
        rd_data   = mem;  rd_valid = 1'b0; wr_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_data  = {$urandom, $urandom};
        req_size  = 2'($urandom);
        for (int c = 1; c <= rl + wl + 20; c++) begin
            if (c > 1) @(negedge clk);
            if (o_rd_en) r.rd_cyc++;
            if (o_wr_en) begin
                if (r.wr_cyc == 0) r.wdata = o_wdata;
                else if (o_wdata !== r.wdata) r.stable = 1'b0;
                r.wr_cyc++;
            end
            if ((o_rd_en || o_wr_en) && o_addr !== exp_addr) r.addr_ok = 1'b0;
            if (o_done) begin
                r.done_cnt++;
                if (r.done_cyc < 0) r.done_cyc = c;
            end
            if (o_mis && r.mis_cyc < 0) r.mis_cyc = c;
            rd_valid = o_rd_en ? (r.rd_cyc == rl) : (o_wr_en ? 1'($urandom) : 1'b0);
            wr_ack   = o_wr_en ? (r.wr_cyc == wl) : (o_rd_en ? 1'($urandom) : 1'b0);
            if (o_done || o_mis) break;
        end
        rd_valid = 1'b0;
        wr_ack   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel32 = 1'b0; req_valid = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0;
        req_addr = '0; req_data = '0; req_size = '0; rd_data = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel32 = 1'(s);
            #1;
            n_vec++;
            if ({o_ready, o_busy, o_rd_en, o_wr_en, o_done, o_mis} !== 6'b100000) begin
                n_err++; $display("FAIL reset_ctrl dw32=%0d: got %b want 100000", s,
                                  {o_ready, o_busy, o_rd_en, o_wr_en, o_done, o_mis});
            end
            n_vec++;
            if (o_addr !== 64'h0 || o_wdata !== 64'h0) begin
                n_err++; $display("FAIL reset_bus dw32=%0d: got addr %h wdata %h want 0", s, o_addr, o_wdata);
            end
        end
        sel32 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_plan();
        res_t r;
        logic [63:0] mem = 64'h1122334455667788;
        sel32 = 1'b0;
        run_store(64'h1003, 64'hAB, mem, 2'd0, 2, 1, r);
        n_vec++;
        if (r.wdata !== 64'h11223344AB667788) begin
            n_err++; $display("FAIL sb_off3: got %h want %h", r.wdata, 64'h11223344AB667788);
        end
        @(negedge clk);
        n_vec++;
        if (r.done_cnt != 1 || o_done !== 1'b0) begin
            n_err++; $display("FAIL sb_done_once: got %0d pulses, done now %b want 1, 0", r.done_cnt, o_done);
        end
        run_store(64'h2006, 64'hBEEF, mem, 2'd1, 1, 3, r);
        n_vec++;
        if (r.wdata !== 64'hBEEF334455667788) begin
            n_err++; $display("FAIL sh_off6: got %h want %h", r.wdata, 64'hBEEF334455667788);
        end
        run_store(64'h3000, 64'hDEADBEEF, mem, 2'd2, 3, 2, r);
        n_vec++;
        if (r.wdata !== 64'h11223344DEADBEEF || r.done_cyc != 7) begin
            n_err++; $display("FAIL sw_off0: got %h done@%0d want %h done@7", r.wdata, r.done_cyc,
                              64'h11223344DEADBEEF);
        end
        run_store(64'h4000, 64'hCAFEF00DCAFEF00D, mem, 2'd3, 2, 3, r);
        n_vec++;
        if (r.rd_cyc != 0 || r.wdata !== 64'hCAFEF00DCAFEF00D || r.done_cyc != 4) begin
            n_err++; $display("FAIL sd_full: got rd %0d wdata %h done@%0d want rd 0 %h done@4",
                              r.rd_cyc, r.wdata, r.done_cyc, 64'hCAFEF00DCAFEF00D);
        end
    endtask

    task automatic test_misaligned();
        res_t r;
        for (int s = 0; s < 2; s++) begin
            sel32 = 1'(s);
            if (s == 0) run_store(64'h5003, 64'h1234, 64'h0, 2'd1, 1, 1, r);
            else        run_store(64'h5000, 64'h1234, 64'h0, 2'd3, 1, 1, r);
            n_vec++;
            if (r.mis_cyc != 1 || r.rd_cyc != 0 || r.wr_cyc != 0 || r.done_cnt != 0) begin
                n_err++; $display("FAIL misaligned dw32=%0d: got mis@%0d rd %0d wr %0d done %0d want 1 0 0 0",
                                  s, r.mis_cyc, r.rd_cyc, r.wr_cyc, r.done_cnt);
            end
            @(negedge clk);
            n_vec++;
            if (o_ready !== 1'b1 || o_mis !== 1'b0) begin
                n_err++; $display("FAIL mis_recover dw32=%0d: got ready %b mis %b want 1 0", s, o_ready, o_mis);
            end
        end
        sel32 = 1'b0;
    endtask

    task automatic test_random();
        res_t r;
        for (int it = 0; it < 40; it++) begin
            logic [63:0] a   = {$urandom, $urandom};
            logic [63:0] d   = {$urandom, $urandom};
            logic [63:0] mem = {$urandom, $urandom};
            logic [1:0]  sz  = 2'($urandom);
            int rl = int'($urandom_range(1, 4));
            int wl = int'($urandom_range(1, 4));
            bit rej, full;
            int exp_done;
            sel32 = 1'(it % 3 == 2);
            if (!sel32) mem = mem & 64'hFFFFFFFFFFFFFFFF;
            else        mem = {32'h0, mem[31:0]};
            rej  = model_reject(a, sz);
            full = ((1 << sz) == nbytes());
            exp_done = rej ? -1 : (full ? wl + 1 : rl + wl + 2);
            run_store(a, d, mem, sz, rl, wl, r);
            n_vec++;
            if (r.done_cyc != exp_done || r.mis_cyc != (rej ? 1 : -1)) begin
                n_err++; $display("FAIL rnd_timing #%0d: got done@%0d mis@%0d want done@%0d mis@%0d",
                                  it, r.done_cyc, r.mis_cyc, exp_done, rej ? 1 : -1);
            end
            n_vec++;
            if (r.rd_cyc != ((rej || full) ? 0 : rl) || r.wr_cyc != (rej ? 0 : wl)) begin
                n_err++; $display("FAIL rnd_handshake #%0d: got rd %0d wr %0d want rd %0d wr %0d",
                                  it, r.rd_cyc, r.wr_cyc, (rej || full) ? 0 : rl, rej ? 0 : wl);
            end
            if (!rej) begin
                n_vec++;
                if (r.wdata !== model_merge(mem, a, d, sz) || !r.stable || !r.addr_ok) begin
                    n_err++; $display("FAIL rnd_merge #%0d: got %h stable %0d addr_ok %0d want %h",
                                      it, r.wdata, r.stable, r.addr_ok, model_merge(mem, a, d, sz));
                end
            end
        end
        sel32 = 1'b0;
    endtask

    task automatic test_back_to_back();
        res_t r;
        logic [63:0] mem = {$urandom, $urandom};
        sel32 = 1'b0;
        run_store(64'h100, 64'h55, mem, 2'd0, 1, 1, r);
        for (int k = 0; k < 4; k++) begin
            logic [63:0] a = {56'h0, 5'($urandom), 3'b000} | 64'(k);
            logic [63:0] d = {$urandom, $urandom};
            run_store(a, d, mem, 2'd0, 1, 1, r);
            n_vec++;
            if (r.ready0 !== 1'b1 || r.done_cyc != 4 || r.wdata !== model_merge(mem, a, d, 2'd0)) begin
                n_err++; $display("FAIL b2b #%0d: got ready %b done@%0d %h want 1 done@4 %h",
                                  k, r.ready0, r.done_cyc, r.wdata, model_merge(mem, a, d, 2'd0));
            end
        end
    endtask

    task automatic test_reset_mid(input bit in_write);
        res_t r;
        bit   wr_seen = 1'b0;
        logic [63:0] mem = 64'h0123456789ABCDEF;
        sel32 = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h2001; req_size = 2'd0; req_data = 64'h5A; rd_data = mem;
        @(negedge clk);
        req_valid = 1'b0;
        if (in_write) begin
            rd_valid = 1'b1;
            @(negedge clk);
            rd_valid = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if ((in_write ? o_wr_en : o_rd_en) !== 1'b1) begin
            n_err++; $display("FAIL mid_state wr=%0d: got rd %b wr %b want phase active", in_write, o_rd_en, o_wr_en);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({o_ready, o_busy, o_rd_en, o_wr_en, o_done, o_mis} !== 6'b100000 ||
            o_addr !== 64'h0 || o_wdata !== 64'h0) begin
            n_err++; $display("FAIL mid_reset wr=%0d: got ctrl %b addr %h wdata %h want 100000 0 0", in_write,
                              {o_ready, o_busy, o_rd_en, o_wr_en, o_done, o_mis}, o_addr, o_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rd_valid = 1'($urandom);
            wr_ack   = 1'($urandom);
            @(negedge clk);
            if (o_wr_en || o_busy) wr_seen = 1'b1;
        end
        rd_valid = 1'b0; wr_ack = 1'b0;
        n_vec++;
        if (wr_seen) begin
            n_err++; $display("FAIL mid_abandon wr=%0d: got activity after reset want idle", in_write);
        end
        run_store(64'h3005, 64'hC3, mem, 2'd0, 2, 2, r);
        n_vec++;
        if (r.wdata !== model_merge(mem, 64'h3005, 64'hC3, 2'd0) || r.done_cyc != 6) begin
            n_err++; $display("FAIL mid_next wr=%0d: got %h done@%0d want %h done@6", in_write, r.wdata,
                              r.done_cyc, model_merge(mem, 64'h3005, 64'hC3, 2'd0));
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_misaligned();
        test_random();
        test_back_to_back();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
